// File: rtl/wav_ctrl_pkg.sv
// Shared types and constants for the WAV playback sequencer.
// Covers the state encoding, sector geometry and the sector-span helper.
package wav_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_WAIT_INIT = 3'd2,
    S_HDR       = 3'd3,
    S_STREAM    = 3'd4,
    S_WAIT_RD   = 3'd5,
    S_FAULT     = 3'd6
  } wav_state_e;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;
  localparam int RETRY_W      = 2;

  // Last sector of the file, counting the header sector as the first one.
  function automatic logic [31:0] sec_span_last(input logic [31:0] start_sec,
                                                input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, start_sec}
        + (({1'b0, len} + 33'(SECTOR_BYTES - 1)) >> SECTOR_SHIFT)
        - 33'd1;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/wav_play_ctrl_if.sv
// Control/data bundle between the playback sequencer and its environment
// (SD init engine, sector reader, sample FIFO, host play control).
interface wav_play_ctrl_if;
  // rd_req is raised with rd_addr and both hold steady until the reader
  // returns a one-cycle rd_ack or rd_err; rd_req drops on the next edge.
  logic        play_en;
  logic        init_start;
  logic        init_done;
  logic        bus_sel;
  logic        fifo_room;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic        rd_err;
  logic [31:0] file_len;
  logic        file_len_vld;
  logic        playing;
  logic        fault;
  logic [15:0] loop_cnt;
  logic [2:0]  state_dbg;

  modport master (
    input  play_en, init_done, fifo_room, rd_ack, rd_err, file_len, file_len_vld,
    output init_start, bus_sel, rd_req, rd_addr, playing, fault, loop_cnt, state_dbg
  );

  modport slave (
    output play_en, init_done, fifo_room, rd_ack, rd_err, file_len, file_len_vld,
    input  init_start, bus_sel, rd_req, rd_addr, playing, fault, loop_cnt, state_dbg
  );
endinterface

// File: rtl/wav_sec_span.sv
// Registered last-sector calculation for the WAV file.
// span_vld follows calc_en by one cycle, when last_sec/len_zero are fresh.
module wav_sec_span
  import wav_ctrl_pkg::*;
#(
  parameter logic [31:0] START_SEC = 32'd107576
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        calc_en,
  input  logic [31:0] file_len,
  output logic [31:0] last_sec,
  output logic        len_zero,
  output logic        span_vld
);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      last_sec <= START_SEC;
      len_zero <= 1'b0;
      span_vld <= 1'b0;
    end else begin
      span_vld <= calc_en;
      if (calc_en) begin
        last_sec <= sec_span_last(START_SEC, file_len);
        len_zero <= (file_len == 32'd0);
      end
    end
  end

endmodule

// File: rtl/wav_play_ctrl.sv
// Playback sequencer: brings up the SD card, reads the WAV header sector,
// then streams sectors into the FIFO, looping at end of file.
module wav_play_ctrl
  import wav_ctrl_pkg::*;
#(
  parameter logic [31:0] START_SEC    = 32'd107576,
  parameter int          RETRY_MAX    = 3,
  parameter int          INIT_TIMEOUT = 50_000_000
) (
  input logic             clk_50m,
  input logic             rst_n,
  wav_play_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE      = S_IDLE;
  localparam logic [2:0] ST_INIT      = S_INIT;
  localparam logic [2:0] ST_WAIT_INIT = S_WAIT_INIT;
  localparam logic [2:0] ST_HDR       = S_HDR;
  localparam logic [2:0] ST_STREAM    = S_STREAM;
  localparam logic [2:0] ST_WAIT_RD   = S_WAIT_RD;
  localparam logic [2:0] ST_FAULT     = S_FAULT;

  localparam logic [25:0]        TMO_LAST  = 26'(INIT_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  logic [2:0]         state;
  logic [25:0]        tmo_cnt;
  logic [RETRY_W-1:0] init_retry, rd_retry;
  logic [RETRY_W-1:0] init_retry_nxt, rd_retry_nxt;
  logic               hdr_done;
  logic [31:0]        next_addr;
  logic [15:0]        loop_cnt_q;
  logic               init_start_q, bus_sel_q, rd_req_q, playing_q, fault_q;
  logic [31:0]        rd_addr_q;
  logic [31:0]        last_sec;
  logic               len_zero, span_vld, calc_en;

  assign init_retry_nxt = init_retry + RETRY_W'(1);
  assign rd_retry_nxt   = rd_retry + RETRY_W'(1);
  assign calc_en        = (state == ST_HDR) && hdr_done && bus.file_len_vld;

  wav_sec_span #(.START_SEC(START_SEC)) u_span (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .calc_en  (calc_en),
    .file_len (bus.file_len),
    .last_sec (last_sec),
    .len_zero (len_zero),
    .span_vld (span_vld)
  );

  // Entering FAULT releases the SPI pins and any outstanding request.
  task automatic go_fault();
    state     <= ST_FAULT;
    fault_q   <= 1'b1;
    rd_req_q  <= 1'b0;
    bus_sel_q <= 1'b0;
    playing_q <= 1'b0;
  endtask

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      init_retry   <= '0;
      rd_retry     <= '0;
      hdr_done     <= 1'b0;
      next_addr    <= START_SEC;
      loop_cnt_q   <= '0;
      init_start_q <= 1'b0;
      bus_sel_q    <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= START_SEC;
      playing_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      init_start_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.play_en) begin
          if (bus.init_done) begin
            bus_sel_q <= 1'b1;
            hdr_done  <= 1'b0;
            state     <= ST_HDR;
          end else begin
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          init_start_q <= 1'b1;
          bus_sel_q    <= 1'b0;
          tmo_cnt      <= '0;
          state        <= ST_WAIT_INIT;
        end
        ST_WAIT_INIT: begin
          if (bus.init_done) begin
            bus_sel_q  <= 1'b1;
            init_retry <= '0;
            hdr_done   <= 1'b0;
            state      <= ST_HDR;
          end else if (tmo_cnt == TMO_LAST) begin
            init_retry <= init_retry_nxt;
            if (init_retry_nxt < RETRY_LIM) state <= ST_INIT;
            else go_fault();
          end else begin
            tmo_cnt <= tmo_cnt + 26'd1;
          end
        end
        ST_HDR: begin
          if (rd_req_q) begin
            if (bus.rd_err) begin
              rd_req_q <= 1'b0;
              rd_retry <= rd_retry_nxt;
              if (rd_retry_nxt >= RETRY_LIM) go_fault();
            end else if (bus.rd_ack) begin
              rd_req_q <= 1'b0;
              rd_retry <= '0;
              hdr_done <= 1'b1;
            end
          end else if (!bus.play_en) begin
            state <= ST_IDLE;
          end else if (!hdr_done) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= START_SEC;
          end else if (span_vld) begin
            if (len_zero) begin
              go_fault();
            end else begin
              next_addr <= (last_sec == START_SEC) ? START_SEC : START_SEC + 32'd1;
              playing_q <= 1'b1;
              state     <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (!bus.play_en) begin
            playing_q <= 1'b0;
            state     <= ST_IDLE;
          end else if (bus.fifo_room) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= next_addr;
            state     <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (rd_req_q) begin
            if (bus.rd_err) begin
              rd_req_q <= 1'b0;
              rd_retry <= rd_retry_nxt;
              if (rd_retry_nxt >= RETRY_LIM) go_fault();
            end else if (bus.rd_ack) begin
              rd_req_q <= 1'b0;
              rd_retry <= '0;
              state    <= ST_STREAM;
              if (rd_addr_q == last_sec) begin
                next_addr  <= START_SEC;
                loop_cnt_q <= loop_cnt_q + 16'd1;
              end else begin
                next_addr <= rd_addr_q + 32'd1;
              end
            end
          end else if (!bus.play_en) begin
            playing_q <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            rd_req_q <= 1'b1;
          end
        end
        ST_FAULT: if (!bus.play_en) begin
          fault_q    <= 1'b0;
          init_retry <= '0;
          rd_retry   <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.init_start = init_start_q;
  assign bus.bus_sel    = bus_sel_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.playing    = playing_q;
  assign bus.fault      = fault_q;
  assign bus.loop_cnt   = loop_cnt_q;
  assign bus.state_dbg  = state;

endmodule
